stoch_sat_addsub_mat: RTL and testbench
=======================================

Name: stoch_sat_addsub_mat

Overview:
Parametrised matrix of stochastic saturating add/subtract elements operating on unipolar bitstreams, one bit per element per cycle. Each element keeps a signed carry/debt counter, so excess ones are carried forward and the output stream tracks clamp(a±b, 0, 1). This extends the fixed subtract-only matrix with a runtime add/sub mode, configurable counter depth, stall/clear control and per-element saturation flags. It sits between stochastic matrix multiply/scale stages in the SC datapath.

Parameters:
NUM_ROWS, 2, matrix rows
NUM_COLS, 2, matrix columns
COUNT_BITS, 4, width of each element's signed two's-complement counter (min 2); range -(2^(COUNT_BITS-1)) .. 2^(COUNT_BITS-1)-1

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
EN  in  1  element update enable; low = hold all state
CLR  in  1  synchronous clear of counters, Y and SAT (priority over EN)
MODE  in  1  0 = subtract (A-B), 1 = add (A+B); global to all elements
A  in  [NUM_ROWS-1:0][NUM_COLS-1:0]  stream bits, operand a
B  in  [NUM_ROWS-1:0][NUM_COLS-1:0]  stream bits, operand b
Y  out  [NUM_ROWS-1:0][NUM_COLS-1:0]  registered result stream bits
SAT  out  [NUM_ROWS-1:0][NUM_COLS-1:0]  registered flag: counter clamped this update

Behaviour:
- One clock (CLK); reset is asynchronous and active-low (nRST). On nRST low: every counter = 0, Y = 0, SAT = 0, immediately, independent of CLK.
- Per element (i,j), each rising edge with nRST high:
  - CLR=1: acc=0, Y=0, SAT=0 (regardless of EN, MODE, A, B).
  - CLR=0, EN=0: acc, Y, SAT hold.
  - CLR=0, EN=1: s = acc + a + (MODE ? b : -b), evaluated at COUNT_BITS+2 signed width (no wrap).
    y = (s >= 1); t = s - y.
    acc_next = clamp(t, MIN, MAX); SAT = (t > MAX) or (t < MIN); Y = y.
- Latency: Y/SAT reflect the A/B sampled on the same edge; visible one cycle after inputs presented.
- Subtract: surplus b bits become negative debt that cancels later a bits; debt bottoms out at MIN (saturation of result at 0). Add: surplus ones stored positively up to MAX; beyond that ones are dropped (saturation at 1), SAT=1.
- MODE change mid-stream: counter is not cleared; new mode applies from the next enabled edge. Callers wanting a fresh result assert CLR.
- Simultaneous CLR and mode change: CLR wins; mode applies after.
- Elements are independent; no cross-element interaction. No combinational path from inputs to outputs.
- Long-run density of Y = clamp(p_a ± p_b, 0, 1) within counter-depth error.

Decomposition:
- Package stoch_pkg: typedef enum logic {STOCH_SUB=1'b0, STOCH_ADD=1'b1} stoch_addsub_mode_t; helper localparams for counter MIN/MAX as functions of COUNT_BITS.
- Sub-module stoch_sat_addsub_elem (parameter COUNT_BITS; ports CLK, nRST, en, clr, mode, a, b, y, sat) holds one counter; top level is a generate array of NUM_ROWS x NUM_COLS instances.

Test Plan:
- Reset: drive A=B=all 1, EN=1, pulse nRST low mid-cycle -> Y=0, SAT=0 immediately; after release with A=1,B=0 sub mode, Y=1 next edge.
- Sub, element (0,0): B=1,A=0 for 3 cycles then A=1,B=0 for 4 cycles -> Y=0 for 3+3 cycles (debt -3 repaid), Y=1 on 4th a-cycle; acc ends 0.
- Sub saturation, COUNT_BITS=4: A=0,B=1 for 10 cycles -> acc pins at -8, SAT=1 on cycles 9-10; then A=1 for 9 cycles -> Y first 1 on 9th.
- Add saturation: MODE=1, A=B=1 for 9 cycles -> Y=1 every cycle, acc reaches 7 at cycle 7, SAT=1 on cycles 8-9; then A=B=0 for 7 cycles -> Y=1 for 7 cycles, then 0.
- EN/CLR: mid-stream EN=0 for 5 cycles with random A/B -> Y, SAT, acc frozen; CLR=1 with EN=0 -> all zero next edge.
- Random density, 2x3 matrix, 4096 cycles, p_a=0.7, p_b=0.2 sub / 0.5 add -> Y density 0.5±0.03 per element, 1.0 for add when p_a+p_b≥1.

Source files
------------

// File: rtl/stoch_sat_addsub_mat_pkg.sv
// Shared types and counter-range helpers for the stochastic saturating add/sub matrix.
package stoch_pkg;

  typedef enum logic {
    STOCH_SUB = 1'b0,
    STOCH_ADD = 1'b1
  } stoch_addsub_mode_t;

  function automatic int cnt_min(input int cb);
    return -(1 << (cb - 1));
  endfunction

  function automatic int cnt_max(input int cb);
    return (1 << (cb - 1)) - 1;
  endfunction

endpackage

// File: rtl/stoch_sat_addsub_mat_elem.sv
// One stochastic add/sub element: signed carry/debt counter, registered y and sat.
module stoch_sat_addsub_elem
  import stoch_pkg::*;
#(
  parameter int COUNT_BITS = 4
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               en,
  input  logic               clr,
  input  stoch_addsub_mode_t mode,
  input  logic               a,
  input  logic               b,
  output logic               y,
  output logic               sat
);

  localparam int SW = COUNT_BITS + 2;
  localparam logic signed [SW-1:0] W_MIN = SW'(cnt_min(COUNT_BITS));
  localparam logic signed [SW-1:0] W_MAX = SW'(cnt_max(COUNT_BITS));

  logic signed [COUNT_BITS-1:0] r_acc;
  logic signed [SW-1:0]         w_acc, w_a, w_b, w_s, w_t;
  logic                         w_y, w_hi, w_lo;
  logic signed [COUNT_BITS-1:0] w_acc_nxt;

  // Two guard bits keep acc +/- 1 +/- 1 from wrapping before the clamp.
  assign w_acc = {{2{r_acc[COUNT_BITS-1]}}, r_acc};
  assign w_a   = {{(SW-1){1'b0}}, a};
  assign w_b   = {{(SW-1){1'b0}}, b};
  assign w_s   = w_acc + w_a + ((mode == STOCH_ADD) ? w_b : -w_b);
  assign w_y   = !w_s[SW-1] && (w_s != '0);
  assign w_t   = w_s - {{(SW-1){1'b0}}, w_y};
  assign w_hi  = w_t > W_MAX;
  assign w_lo  = w_t < W_MIN;
  assign w_acc_nxt = w_hi ? W_MAX[COUNT_BITS-1:0] :
                     w_lo ? W_MIN[COUNT_BITS-1:0] : w_t[COUNT_BITS-1:0];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_acc <= '0;
      y     <= 1'b0;
      sat   <= 1'b0;
    end else if (clr) begin
      r_acc <= '0;
      y     <= 1'b0;
      sat   <= 1'b0;
    end else if (en) begin
      r_acc <= w_acc_nxt;
      y     <= w_y;
      sat   <= w_hi | w_lo;
    end
  end

endmodule

// File: rtl/stoch_sat_addsub_mat.sv
// NUM_ROWS x NUM_COLS array of independent stochastic saturating add/sub elements.
module stoch_sat_addsub_mat
  import stoch_pkg::*;
#(
  parameter int NUM_ROWS   = 2,
  parameter int NUM_COLS   = 2,
  parameter int COUNT_BITS = 4
) (
  input  logic                               CLK,
  input  logic                               nRST,
  input  logic                               EN,
  input  logic                               CLR,
  input  logic                               MODE,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]  A,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]  B,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0]  Y,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0]  SAT
);

  stoch_addsub_mode_t w_mode;
  assign w_mode = stoch_addsub_mode_t'(MODE);

  for (genvar gr = 0; gr < NUM_ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < NUM_COLS; gc++) begin : g_col
      stoch_sat_addsub_elem #(
        .COUNT_BITS (COUNT_BITS)
      ) u_elem (
        .CLK  (CLK),
        .nRST (nRST),
        .en   (EN),
        .clr  (CLR),
        .mode (w_mode),
        .a    (A[gr][gc]),
        .b    (B[gr][gc]),
        .y    (Y[gr][gc]),
        .sat  (SAT[gr][gc])
      );
    end
  end

endmodule

// File: tb/tb_stoch_sat_addsub_mat.sv
// Scoreboard bench: driver pushes model-predicted Y/SAT per edge, monitor pops and compares.
module tb_stoch_sat_addsub_mat;

  localparam int NR   = 2;
  localparam int NC   = 3;
  localparam int CB   = 4;
  localparam int MINV = -8;
  localparam int MAXV = 7;
  localparam int DN   = 4096;

  typedef logic [NR-1:0][NC-1:0] mat_t;
  typedef struct packed {
    mat_t y;
    mat_t sat;
  } exp_t;

  logic CLK = 1'b0;
  logic nRST, EN, CLR, MODE;
  mat_t A, B, Y, SAT;

  stoch_sat_addsub_mat #(.NUM_ROWS(NR), .NUM_COLS(NC), .COUNT_BITS(CB)) dut (
    .CLK(CLK), .nRST(nRST), .EN(EN), .CLR(CLR), .MODE(MODE),
    .A(A), .B(B), .Y(Y), .SAT(SAT)
  );

  always #5 CLK = ~CLK;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  int   macc[NR][NC];
  bit   ey[NR][NC];
  bit   es[NR][NC];
  bit   dens = 0;
  int   ones[NR][NC];
  int   acnt[NR][NC];
  int   bcnt[NR][NC];

  mat_t ALL1, ALL0;

  task automatic model_reset();
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < NC; j++) begin
        macc[i][j] = 0; ey[i][j] = 0; es[i][j] = 0;
      end
  endtask

  task automatic step(input bit en, input bit clr, input bit mode, input mat_t a, input mat_t b);
    exp_t e;
    int   s, t, yy;
    @(negedge CLK);
    EN = en; CLR = clr; MODE = mode; A = a; B = b;
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < NC; j++) begin
        if (clr) begin
          macc[i][j] = 0; ey[i][j] = 0; es[i][j] = 0;
        end else if (en) begin
          s  = macc[i][j] + int'(a[i][j]) + (mode ? int'(b[i][j]) : -int'(b[i][j]));
          yy = (s >= 1) ? 1 : 0;
          t  = s - yy;
          es[i][j]   = (t > MAXV) || (t < MINV);
          macc[i][j] = (t > MAXV) ? MAXV : (t < MINV) ? MINV : t;
          ey[i][j]   = (yy == 1);
        end
        e.y[i][j]   = ey[i][j];
        e.sat[i][j] = es[i][j];
        if (dens) begin
          acnt[i][j] += int'(a[i][j]);
          bcnt[i][j] += int'(b[i][j]);
        end
      end
    q.push_back(e);
  endtask

  task automatic run(input int n, input bit en, input bit clr, input bit mode, input mat_t a, input mat_t b);
    for (int k = 0; k < n; k++) step(en, clr, mode, a, b);
  endtask

  function automatic mat_t rvec(input int permille);
    mat_t v;
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < NC; j++)
        v[i][j] = ($urandom_range(999) < permille);
    return v;
  endfunction

  task automatic density(input bit mode, input int pa, input int pb);
    real yd, ed, fa, fb;
    step(1'b0, 1'b1, mode, ALL0, ALL0);
    @(posedge CLK); #2;
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < NC; j++) begin
        ones[i][j] = 0; acnt[i][j] = 0; bcnt[i][j] = 0;
      end
    dens = 1;
    for (int k = 0; k < DN; k++) step(1'b1, 1'b0, mode, rvec(pa), rvec(pb));
    @(posedge CLK); #2;
    dens = 0;
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < NC; j++) begin
        fa = real'(acnt[i][j]) / DN;
        fb = real'(bcnt[i][j]) / DN;
        ed = mode ? fa + fb : fa - fb;
        if (ed > 1.0) ed = 1.0;
        if (ed < 0.0) ed = 0.0;
        yd = real'(ones[i][j]) / DN;
        total++;
        if (yd > ed + 0.03 || yd < ed - 0.03) begin
          bad++;
          $display("FAIL density mode=%0d (%0d,%0d): got %f want %f", mode, i, j, yd, ed);
        end
      end
  endtask

  // Monitor: every edge that had stimulus queued presents one result.
  always begin
    exp_t e;
    @(posedge CLK);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (Y !== e.y || SAT !== e.sat) begin
        bad++;
        $display("FAIL stream @%0t: Y=%h SAT=%h want Y=%h SAT=%h", $time, Y, SAT, e.y, e.sat);
      end
      if (dens)
        for (int i = 0; i < NR; i++)
          for (int j = 0; j < NC; j++)
            ones[i][j] += int'(Y[i][j]);
    end
  end

  initial begin
    ALL1 = '1; ALL0 = '0;
    nRST = 1'b0; EN = 1'b0; CLR = 1'b0; MODE = 1'b0; A = '0; B = '0;
    model_reset();
    #12;
    total++;
    if (Y !== '0 || SAT !== '0) begin
      bad++;
      $display("FAIL reset_state: Y=%h SAT=%h want 0 0", Y, SAT);
    end
    @(negedge CLK); nRST = 1'b1;

    // async reset mid-cycle while outputs are high
    run(9, 1'b1, 1'b0, 1'b1, ALL1, ALL1);
    @(posedge CLK); #3;
    nRST = 1'b0;
    #1;
    total++;
    if (Y !== '0 || SAT !== '0) begin
      bad++;
      $display("FAIL async_reset: Y=%h SAT=%h want 0 0", Y, SAT);
    end
    model_reset();
    @(negedge CLK); nRST = 1'b1;
    run(1, 1'b1, 1'b0, 1'b0, ALL1, ALL0);

    // subtract debt repay
    run(1, 1'b0, 1'b1, 1'b0, ALL0, ALL0);
    run(3, 1'b1, 1'b0, 1'b0, ALL0, ALL1);
    run(4, 1'b1, 1'b0, 1'b0, ALL1, ALL0);

    // subtract saturation at MIN, then repay
    run(1, 1'b0, 1'b1, 1'b0, ALL0, ALL0);
    run(10, 1'b1, 1'b0, 1'b0, ALL0, ALL1);
    run(9, 1'b1, 1'b0, 1'b0, ALL1, ALL0);

    // add saturation at MAX, then drain
    run(1, 1'b0, 1'b1, 1'b1, ALL0, ALL0);
    run(9, 1'b1, 1'b0, 1'b1, ALL1, ALL1);
    run(8, 1'b1, 1'b0, 1'b1, ALL0, ALL0);

    // hold under EN=0, then CLR with EN=0, then mode switch without clear
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b1, rvec(700), rvec(500));
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, k[0], rvec(500), rvec(500));
    run(1, 1'b0, 1'b1, 1'b1, ALL1, ALL1);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b1, ALL1, ALL1);
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b0, ALL0, ALL1);
    run(1, 1'b1, 1'b1, 1'b0, ALL1, ALL0);

    // random control mix
    for (int k = 0; k < 400; k++)
      step($urandom_range(99) < 80, $urandom_range(99) < 3, $urandom_range(99) < 50,
           rvec($urandom_range(1000)), rvec($urandom_range(1000)));

    density(1'b0, 700, 200);
    density(1'b1, 700, 500);

    @(posedge CLK); #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d results left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
